// File: rtl/des_pkg.sv
// Shared DES constants: FSM state type, key-schedule shift table and the
// FIPS 46-3 bit-selection tables (1-based, bit 1 = MSB), plus permutation helpers.
package des_pkg;

    localparam int ROUNDS = 16;
    localparam int CNT_W  = 5;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    localparam int SHIFT_TAB [16] = '{1, 1, 2, 2, 2, 2, 2, 2, 1, 2, 2, 2, 2, 2, 2, 1};

    localparam int PC1_TAB [56] = '{
        57, 49, 41, 33, 25, 17,  9,
         1, 58, 50, 42, 34, 26, 18,
        10,  2, 59, 51, 43, 35, 27,
        19, 11,  3, 60, 52, 44, 36,
        63, 55, 47, 39, 31, 23, 15,
         7, 62, 54, 46, 38, 30, 22,
        14,  6, 61, 53, 45, 37, 29,
        21, 13,  5, 28, 20, 12,  4
    };

    localparam int PC2_TAB [48] = '{
        14, 17, 11, 24,  1,  5,
         3, 28, 15,  6, 21, 10,
        23, 19, 12,  4, 26,  8,
        16,  7, 27, 20, 13,  2,
        41, 52, 31, 37, 47, 55,
        30, 40, 51, 45, 33, 48,
        44, 49, 39, 56, 34, 53,
        46, 42, 50, 36, 29, 32
    };

    localparam int E_TAB [48] = '{
        32,  1,  2,  3,  4,  5,
         4,  5,  6,  7,  8,  9,
         8,  9, 10, 11, 12, 13,
        12, 13, 14, 15, 16, 17,
        16, 17, 18, 19, 20, 21,
        20, 21, 22, 23, 24, 25,
        24, 25, 26, 27, 28, 29,
        28, 29, 30, 31, 32,  1
    };

    localparam int P_TAB [32] = '{
        16,  7, 20, 21,
        29, 12, 28, 17,
         1, 15, 23, 26,
         5, 18, 31, 10,
         2,  8, 24, 14,
        32, 27,  3,  9,
        19, 13, 30,  6,
        22, 11,  4, 25
    };

    function automatic logic [55:0] pc1(input logic [63:0] k);
        logic [55:0] r;
        r = '0;
        for (int i = 0; i < 56; i++) begin
            r[6'(55 - i)] = k[6'(64 - PC1_TAB[6'(i)])];
        end
        return r;
    endfunction

    function automatic logic [47:0] pc2(input logic [55:0] cd);
        logic [47:0] r;
        r = '0;
        for (int i = 0; i < 48; i++) begin
            r[6'(47 - i)] = cd[6'(56 - PC2_TAB[6'(i)])];
        end
        return r;
    endfunction

    function automatic logic [47:0] e_expand(input logic [31:0] x);
        logic [47:0] r;
        r = '0;
        for (int i = 0; i < 48; i++) begin
            r[6'(47 - i)] = x[5'(32 - E_TAB[6'(i)])];
        end
        return r;
    endfunction

    function automatic logic [31:0] p_perm(input logic [31:0] x);
        logic [31:0] r;
        r = '0;
        for (int i = 0; i < 32; i++) begin
            r[5'(31 - i)] = x[5'(32 - P_TAB[5'(i)])];
        end
        return r;
    endfunction

    function automatic logic [27:0] rot_left(input logic [27:0] x, input logic two);
        return two ? {x[25:0], x[27:26]} : {x[26:0], x[27]};
    endfunction

    function automatic logic [27:0] rot_right(input logic [27:0] x, input logic two);
        return two ? {x[1:0], x[27:2]} : {x[0], x[27:1]};
    endfunction

    // A byte with even parity marks a corrupted key (DES keys use odd parity).
    function automatic logic key_parity_err(input logic [63:0] k);
        logic err;
        err = 1'b0;
        for (int b = 0; b < 8; b++) begin
            err = err | ~^k[6'(b * 8) +: 8];
        end
        return err;
    endfunction

endpackage

// File: rtl/des_sbox.sv
// Combinational DES substitution: eight 6-to-4 S-boxes, 48 bits in, 32 bits out.
module des_sbox (
    input  logic [47:0] din,
    output logic [31:0] dout
);

    // Entry index is {row, col} with row = {b1,b6} and col = b2..b5 of each 6-bit group.
    localparam int SBOX [8][64] = '{
        '{14,  4, 13,  1,  2, 15, 11,  8,  3, 10,  6, 12,  5,  9,  0,  7,
           0, 15,  7,  4, 14,  2, 13,  1, 10,  6, 12, 11,  9,  5,  3,  8,
           4,  1, 14,  8, 13,  6,  2, 11, 15, 12,  9,  7,  3, 10,  5,  0,
          15, 12,  8,  2,  4,  9,  1,  7,  5, 11,  3, 14, 10,  0,  6, 13},
        '{15,  1,  8, 14,  6, 11,  3,  4,  9,  7,  2, 13, 12,  0,  5, 10,
           3, 13,  4,  7, 15,  2,  8, 14, 12,  0,  1, 10,  6,  9, 11,  5,
           0, 14,  7, 11, 10,  4, 13,  1,  5,  8, 12,  6,  9,  3,  2, 15,
          13,  8, 10,  1,  3, 15,  4,  2, 11,  6,  7, 12,  0,  5, 14,  9},
        '{10,  0,  9, 14,  6,  3, 15,  5,  1, 13, 12,  7, 11,  4,  2,  8,
          13,  7,  0,  9,  3,  4,  6, 10,  2,  8,  5, 14, 12, 11, 15,  1,
          13,  6,  4,  9,  8, 15,  3,  0, 11,  1,  2, 12,  5, 10, 14,  7,
           1, 10, 13,  0,  6,  9,  8,  7,  4, 15, 14,  3, 11,  5,  2, 12},
        '{ 7, 13, 14,  3,  0,  6,  9, 10,  1,  2,  8,  5, 11, 12,  4, 15,
          13,  8, 11,  5,  6, 15,  0,  3,  4,  7,  2, 12,  1, 10, 14,  9,
          10,  6,  9,  0, 12, 11,  7, 13, 15,  1,  3, 14,  5,  2,  8,  4,
           3, 15,  0,  6, 10,  1, 13,  8,  9,  4,  5, 11, 12,  7,  2, 14},
        '{ 2, 12,  4,  1,  7, 10, 11,  6,  8,  5,  3, 15, 13,  0, 14,  9,
          14, 11,  2, 12,  4,  7, 13,  1,  5,  0, 15, 10,  3,  9,  8,  6,
           4,  2,  1, 11, 10, 13,  7,  8, 15,  9, 12,  5,  6,  3,  0, 14,
          11,  8, 12,  7,  1, 14,  2, 13,  6, 15,  0,  9, 10,  4,  5,  3},
        '{12,  1, 10, 15,  9,  2,  6,  8,  0, 13,  3,  4, 14,  7,  5, 11,
          10, 15,  4,  2,  7, 12,  9,  5,  6,  1, 13, 14,  0, 11,  3,  8,
           9, 14, 15,  5,  2,  8, 12,  3,  7,  0,  4, 10,  1, 13, 11,  6,
           4,  3,  2, 12,  9,  5, 15, 10, 11, 14,  1,  7,  6,  0,  8, 13},
        '{ 4, 11,  2, 14, 15,  0,  8, 13,  3, 12,  9,  7,  5, 10,  6,  1,
          13,  0, 11,  7,  4,  9,  1, 10, 14,  3,  5, 12,  2, 15,  8,  6,
           1,  4, 11, 13, 12,  3,  7, 14, 10, 15,  6,  8,  0,  5,  9,  2,
           6, 11, 13,  8,  1,  4, 10,  7,  9,  5,  0, 15, 14,  2,  3, 12},
        '{13,  2,  8,  4,  6, 15, 11,  1, 10,  9,  3, 14,  5,  0, 12,  7,
           1, 15, 13,  8, 10,  3,  7,  4, 12,  5,  6, 11,  0, 14,  9,  2,
           7, 11,  4,  1,  9, 12, 14,  2,  0,  6, 10, 13, 15,  3,  5,  8,
           2,  1, 14,  7,  4, 10,  8, 13, 15, 12,  9,  0,  3,  5,  6, 11}
    };

    always_comb begin
        logic [5:0] chunk;
        dout  = '0;
        chunk = '0;
        for (int k = 0; k < 8; k++) begin
            chunk = din[6'(47 - 6 * k) -: 6];
            dout[5'(31 - 4 * k) -: 4] = 4'(SBOX[3'(k)][{chunk[5], chunk[0], chunk[4:1]}]);
        end
    end

endmodule

// File: rtl/des_round_engine.sv
// Iterative one-round-per-clock DES Feistel core with on-the-fly key schedule.
// Optional key parity check is built when DES_KEY_PARITY_CHECK_EN is defined.
//
// state   | meaning
// IDLE    | waiting for a block, in_ready high
// RUN     | executing rounds 1..16, one per clock
// DONE    | {R16,L16} presented, held until out_ready
module des_round_engine
    import des_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [63:0] in_data,
    input  logic [63:0] in_key,
    input  logic        in_decrypt,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [63:0] out_data,
    output logic        key_err
);

    state_t            state;
    logic [31:0]       l_reg;
    logic [31:0]       r_reg;
    logic [27:0]       c_reg;
    logic [27:0]       d_reg;
    logic              decrypt;
    logic [CNT_W-1:0]  round_cnt;

    logic              accept;
    logic              shift_two;
    logic [27:0]       c_rot;
    logic [27:0]       d_rot;
    logic [47:0]       round_key;
    logic [47:0]       sbox_in;
    logic [31:0]       sbox_out;
    logic [31:0]       f_out;
    logic [31:0]       r_next;

    assign accept = (state == ST_IDLE) && in_valid && in_ready;

    // Decrypt walks the schedule backwards: round 1 reuses C0/D0 (= C16/D16).
    always_comb begin
        shift_two = '0;
        c_rot     = c_reg;
        d_rot     = d_reg;
        if (!decrypt) begin
            shift_two = (SHIFT_TAB[4'(round_cnt - 5'd1)] == 2);
            c_rot     = rot_left(c_reg, shift_two);
            d_rot     = rot_left(d_reg, shift_two);
        end else if (round_cnt != 5'd1) begin
            shift_two = (SHIFT_TAB[4'(5'd17 - round_cnt)] == 2);
            c_rot     = rot_right(c_reg, shift_two);
            d_rot     = rot_right(d_reg, shift_two);
        end
    end

    assign round_key = pc2({c_rot, d_rot});
    assign sbox_in   = e_expand(r_reg) ^ round_key;

    des_sbox u_sbox (
        .din  (sbox_in),
        .dout (sbox_out)
    );

    assign f_out  = p_perm(sbox_out);
    assign r_next = l_reg ^ f_out;

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= ST_IDLE;
            in_ready  <= 1'b0;
            out_valid <= 1'b0;
            out_data  <= '0;
            round_cnt <= '0;
            l_reg     <= '0;
            r_reg     <= '0;
            c_reg     <= '0;
            d_reg     <= '0;
            decrypt   <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    in_ready <= 1'b1;
                    if (accept) begin
                        l_reg          <= in_data[63:32];
                        r_reg          <= in_data[31:0];
                        {c_reg, d_reg} <= pc1(in_key);
                        decrypt        <= in_decrypt;
                        round_cnt      <= 5'd1;
                        in_ready       <= 1'b0;
                        state          <= ST_RUN;
                    end
                end
                ST_RUN: begin
                    l_reg <= r_reg;
                    r_reg <= r_next;
                    c_reg <= c_rot;
                    d_reg <= d_rot;
                    if (round_cnt == CNT_W'(ROUNDS)) begin
                        out_data  <= {r_next, r_reg};
                        out_valid <= 1'b1;
                        state     <= ST_DONE;
                    end else begin
                        round_cnt <= round_cnt + 5'd1;
                    end
                end
                ST_DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                        state     <= ST_IDLE;
                    end
                end
                default: begin
                    state    <= ST_IDLE;
                    in_ready <= 1'b0;
                end
            endcase
        end
    end

`ifdef DES_KEY_PARITY_CHECK_EN
    // Captured at acceptance; consumers only look at it alongside out_valid.
    always_ff @(posedge clk) begin
        if (rst) begin
            key_err <= 1'b0;
        end else if (accept) begin
            key_err <= key_parity_err(in_key);
        end
    end
`else
    assign key_err = 1'b0;
`endif

endmodule
